iic_slave_regs: RTL and testbench
=================================

IIC_SLAVE_REGS -- requirements
Module: iic_slave_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, meaning the 7-bit target address this block answers.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports scl_i and sda_i, input, 1 bit each: raw bus levels, asynchronous to clk.
REQ-005 SHALL have port sda_o, output, 1 bit: 0 drives SDA low, 1 releases it (open-drain).
REQ-006 SHALL have port reg_addr, output, 8 bits: the current register pointer.
REQ-007 SHALL have ports wr_en (output, 1 bit) and wr_data (output, 8 bits): a register write strobe and its byte.
REQ-008 SHALL have ports rd_req (output, 1 bit) and rd_data (input, 8 bits): a read prefetch strobe and the returned byte.
REQ-009 SHALL have port busy, output, 1 bit: high from a detected START until a STOP or a reset.

Function
REQ-010 SHALL pass scl_i and sda_i through 2-FF synchronizers plus one history register, and SHALL take edge events from the synchronized values (3 clk input latency).
REQ-011 SHALL support a clk frequency of at least 20x the SCL frequency; behaviour below that ratio is undefined.
REQ-012 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-013 SHALL sample SDA on the synchronized SCL rising edge, and SHALL change sda_o 1 clk after the synchronized SCL falling edge.
REQ-014 SHALL implement these states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-015 SHALL enter ADDR and clear the bit counter on START in any state, including a repeated START.
REQ-016 SHALL go to IDLE on STOP in any state, release sda_o, and discard any partial byte.
REQ-017 In ADDR, after 8 bits are shifted in MSB first:
- If bits[7:1] equal DEV_ADDR, SHALL go to ADDR_ACK and drive sda_o=0 for one SCL period.
- Otherwise SHALL go to WAIT_STOP with sda_o=1.
- WAIT_STOP SHALL ignore all traffic until START or STOP.
REQ-018 After ADDR_ACK, SHALL go to PTR if R/W=0, or to RDATA if R/W=1.
REQ-019 The first write byte SHALL load the pointer and be ACKed in PTR_ACK, with no wr_en pulse.
REQ-020 For each later write byte, on the 8th rising SCL edge:
- wr_en SHALL pulse for 1 clk, with wr_data = the byte and reg_addr = the current pointer.
- The pointer SHALL increment on the next clk.
- WDATA_ACK SHALL drive the ACK.
REQ-021 rd_req SHALL pulse for 1 clk at the SCL falling edge that starts ADDR_ACK (read) and at the one that starts each RDATA_ACK.
REQ-022 rd_data SHALL be valid at the next SCL falling edge after rd_req; the block SHALL then load rd_data into the shifter and increment the pointer.
REQ-023 In RDATA, SHALL drive the shifter MSB first on sda_o; in RDATA_ACK, SHALL release sda_o and sample the controller's bit.
- ACK (0): SHALL go to RDATA.
- NAK (1): SHALL go to WAIT_STOP.
REQ-024 The pointer SHALL wrap from 8'hFF to 8'h00 with no error indication.
REQ-025 START or STOP during an ACK slot SHALL release sda_o within 1 clk.
REQ-026 The pointer SHALL persist across transactions and SHALL be changed only by PTR, increments, or reset.

Reset
REQ-027 While rst_n=0, the block SHALL be in IDLE with sda_o=1, reg_addr=8'h00, wr_en=0, wr_data=8'h00, rd_req=0, busy=0, synchronizers=1, and bit counter=0.
REQ-028 Assertion of rst_n=0 SHALL take effect immediately, including mid-byte and while SDA is being driven low.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Write: START, 0xA0, 0x10, 0x5A, 0x3C, STOP -> 4 ACKs; wr_en with (0x10, 0x5A), then (0x11, 0x3C); reg_addr=0x12 at end.
- Mismatch: START, 0xA2, 0x10, STOP -> sda_o=1 throughout; no wr_en; reg_addr unchanged.
- Read: START, 0xA0, 0x20, repeated START, 0xA1, read 2 bytes (ACK then NAK), STOP -> rd_req at 0x20, 0x21, 0x22; bus bytes equal the rd_data returned for 0x20 and 0x21; reg_addr=0x22.
- Wrap: START, 0xA0, 0xFF, 0x11, 0x22, STOP -> writes at 0xFF, then 0x00.
- Abort: STOP after 5 bits of a data byte -> no wr_en; IDLE; busy=0.
- Reset: rst_n=0 mid read with sda_o=0 -> sda_o=1 the same cycle, all outputs at reset values; the next write transaction succeeds.

Source files
------------

// File: rtl/iic_slave_regs_if.sv
// Bus-side and register-side signals of the I2C register target, bundled.
// The slave modport is the target block; the master modport is its environment.
`timescale 1ns/1ps
interface iic_slave_regs_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic [7:0] reg_addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, rd_data,
    output sda_o, reg_addr, wr_en, wr_data, rd_req, busy
  );

  modport master (
    output scl_i, sda_i, rd_data,
    input  sda_o, reg_addr, wr_en, wr_data, rd_req, busy
  );
endinterface

// File: rtl/iic_slave_regs.sv
// I2C target with an 8-bit auto-incrementing register pointer.
// SCL/SDA are oversampled by clk; all bus decisions come from synchronized edges.
`timescale 1ns/1ps
module iic_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic             clk,
  input  logic             rst_n,
  iic_slave_regs_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  // Bit 1 carries SCL, bit 0 carries SDA.
  logic [1:0] raw_in;
  logic [1:0] sync_v;
  logic [1:0] hist_v;

  assign raw_in = {bus.scl_i, bus.sda_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg, s2_reg, h_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
          h_reg  <= 1'b1;
        end else begin
          s1_reg <= raw_in[gi];
          s2_reg <= s1_reg;
          h_reg  <= s2_reg;
        end
      end
      assign sync_v[gi] = s2_reg;
      assign hist_v[gi] = h_reg;
    end
  endgenerate

  logic scl_s, sda_s, scl_h, sda_h;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = sync_v[1];
  assign sda_s     = sync_v[0];
  assign scl_h     = hist_v[1];
  assign sda_h     = hist_v[0];
  assign scl_rise  =  scl_s & ~scl_h;
  assign scl_fall  = ~scl_s &  scl_h;
  assign start_det =  scl_s &  scl_h &  sda_h & ~sda_s;
  assign stop_det  =  scl_s &  scl_h & ~sda_h &  sda_s;

  state_t     state_reg;
  logic [3:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [7:0] ptr_reg;
  logic       sda_o_reg;
  logic       wr_en_reg;
  logic [7:0] wr_data_reg;
  logic       rd_req_reg;
  logic       busy_reg;
  logic       nak_reg;
  logic [7:0] byte_in;

  assign byte_in = {shift_reg[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 8'h00;
      ptr_reg     <= 8'h00;
      sda_o_reg   <= 1'b1;
      wr_en_reg   <= 1'b0;
      wr_data_reg <= 8'h00;
      rd_req_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      nak_reg     <= 1'b0;
    end else begin
      wr_en_reg  <= 1'b0;
      rd_req_reg <= 1'b0;
      // The write strobe presents the old pointer; it advances one clk later.
      if (wr_en_reg) ptr_reg <= ptr_reg + 8'd1;

      if (start_det) begin
        state_reg   <= ADDR;
        bit_cnt_reg <= 4'd0;
        sda_o_reg   <= 1'b1;
        busy_reg    <= 1'b1;
      end else if (stop_det) begin
        state_reg   <= IDLE;
        bit_cnt_reg <= 4'd0;
        sda_o_reg   <= 1'b1;
        busy_reg    <= 1'b0;
      end else if (scl_rise) begin
        case (state_reg)
          ADDR, PTR, WDATA: begin
            if (bit_cnt_reg != 4'd8) begin
              shift_reg   <= byte_in;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                if (state_reg == PTR) ptr_reg <= byte_in;
                if (state_reg == WDATA) begin
                  wr_en_reg   <= 1'b1;
                  wr_data_reg <= byte_in;
                end
              end
            end
          end
          RDATA:     bit_cnt_reg <= bit_cnt_reg + 4'd1;
          RDATA_ACK: nak_reg     <= sda_s;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_reg)
          ADDR: begin
            if (bit_cnt_reg == 4'd8) begin
              bit_cnt_reg <= 4'd0;
              if (shift_reg[7:1] == DEV_ADDR) begin
                state_reg  <= ADDR_ACK;
                sda_o_reg  <= 1'b0;
                rd_req_reg <= shift_reg[0];
              end else begin
                state_reg <= WAIT_STOP;
                sda_o_reg <= 1'b1;
              end
            end
          end
          PTR, WDATA: begin
            if (bit_cnt_reg == 4'd8) begin
              state_reg   <= (state_reg == PTR) ? PTR_ACK : WDATA_ACK;
              bit_cnt_reg <= 4'd0;
              sda_o_reg   <= 1'b0;
            end
          end
          ADDR_ACK: begin
            // shift_reg[0] still holds the R/W bit of the address byte.
            if (shift_reg[0]) begin
              state_reg   <= RDATA;
              shift_reg   <= bus.rd_data;
              sda_o_reg   <= bus.rd_data[7];
              ptr_reg     <= ptr_reg + 8'd1;
              bit_cnt_reg <= 4'd0;
            end else begin
              state_reg <= PTR;
              sda_o_reg <= 1'b1;
            end
          end
          PTR_ACK, WDATA_ACK: begin
            state_reg <= WDATA;
            sda_o_reg <= 1'b1;
          end
          RDATA: begin
            if (bit_cnt_reg == 4'd8) begin
              state_reg  <= RDATA_ACK;
              sda_o_reg  <= 1'b1;
              rd_req_reg <= 1'b1;
            end else begin
              shift_reg <= {shift_reg[6:0], 1'b0};
              sda_o_reg <= shift_reg[6];
            end
          end
          RDATA_ACK: begin
            if (nak_reg) begin
              state_reg <= WAIT_STOP;
              sda_o_reg <= 1'b1;
            end else begin
              state_reg   <= RDATA;
              shift_reg   <= bus.rd_data;
              sda_o_reg   <= bus.rd_data[7];
              ptr_reg     <= ptr_reg + 8'd1;
              bit_cnt_reg <= 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_o    = sda_o_reg;
  assign bus.reg_addr = ptr_reg;
  assign bus.wr_en    = wr_en_reg;
  assign bus.wr_data  = wr_data_reg;
  assign bus.rd_req   = rd_req_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_iic_slave_regs.sv
// Directed bench for iic_slave_regs: a bit-banged controller on a wired-AND SDA
// line plus a register-file responder that answers rd_req with addr ^ 8'h5C.
`timescale 1ns/1ps
module tb_iic_slave_regs;
  localparam time Q = 100ns;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] rd_data_tb = 8'h00;

  always #5 clk = ~clk;

  iic_slave_regs_if bus();
  assign bus.scl_i   = scl_m;
  assign bus.sda_i   = sda_m & bus.sda_o;
  assign bus.rd_data = rd_data_tb;

  iic_slave_regs #(.DEV_ADDR(7'h50)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [7:0] rd_addr_q[$];
  int         sda_low_cnt = 0;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wr_addr_q.push_back(bus.reg_addr);
      wr_data_q.push_back(bus.wr_data);
      $display("reg write addr=%02h data=%02h", bus.reg_addr, bus.wr_data);
    end
    if (bus.rd_req) begin
      rd_addr_q.push_back(bus.reg_addr);
      rd_data_tb <= bus.reg_addr ^ 8'h5C;
      $display("reg read  addr=%02h data=%02h", bus.reg_addr, bus.reg_addr ^ 8'h5C);
    end
    if (!bus.sda_o) sda_low_cnt <= sda_low_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #(2*Q);
    sda_m = 1'b0; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #(2*Q);
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    ack = bus.sda_i; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      b[i] = bus.sda_i; #Q;
      scl_m = 1'b0; #Q;
    end
    sda_m = ack_bit; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
    sda_m = 1'b1;
  endtask

  logic       ack;
  logic [7:0] b0, b1;
  int         base, low0;

  initial begin
    // Reset state
    #52;
    check("rst_sda_o",    bus.sda_o,    1);
    check("rst_reg_addr", bus.reg_addr, 8'h00);
    check("rst_wr_en",    bus.wr_en,    0);
    check("rst_wr_data",  bus.wr_data,  8'h00);
    check("rst_rd_req",   bus.rd_req,   0);
    check("rst_busy",     bus.busy,     0);
    rst_n = 1'b1;
    #(4*Q);

    // Write: pointer 0x10, data 0x5A, 0x3C
    i2c_start();
    check("wr_busy", bus.busy, 1);
    send_byte(8'hA0, ack); check("wr_ack_addr", ack, 0);
    send_byte(8'h10, ack); check("wr_ack_ptr",  ack, 0);
    send_byte(8'h5A, ack); check("wr_ack_d0",   ack, 0);
    send_byte(8'h3C, ack); check("wr_ack_d1",   ack, 0);
    i2c_stop(); #Q;
    $display("txn write ptr=10 data=5A,3C done");
    check("wr_count",    wr_addr_q.size(), 2);
    check("wr_addr0",    wr_addr_q[0], 8'h10);
    check("wr_data0",    wr_data_q[0], 8'h5A);
    check("wr_addr1",    wr_addr_q[1], 8'h11);
    check("wr_data1",    wr_data_q[1], 8'h3C);
    check("wr_reg_addr", bus.reg_addr, 8'h12);
    check("wr_busy_end", bus.busy, 0);

    // Address mismatch: no ACK, no writes, pointer untouched
    low0 = sda_low_cnt;
    base = wr_addr_q.size();
    i2c_start();
    send_byte(8'hA2, ack); check("mm_nak_addr", ack, 1);
    send_byte(8'h10, ack); check("mm_nak_data", ack, 1);
    i2c_stop(); #Q;
    $display("txn mismatch addr=A2 done");
    check("mm_sda_low",  sda_low_cnt - low0, 0);
    check("mm_wr_count", wr_addr_q.size() - base, 0);
    check("mm_reg_addr", bus.reg_addr, 8'h12);

    // Read: set pointer 0x20, repeated START, read two bytes
    i2c_start();
    send_byte(8'hA0, ack); check("rd_ack_waddr", ack, 0);
    send_byte(8'h20, ack); check("rd_ack_ptr",   ack, 0);
    i2c_start();
    send_byte(8'hA1, ack); check("rd_ack_raddr", ack, 0);
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    i2c_stop(); #Q;
    $display("txn read ptr=20 got %02h %02h", b0, b1);
    check("rd_byte0",    b0, 8'h7C);
    check("rd_byte1",    b1, 8'h7D);
    check("rd_req_cnt",  rd_addr_q.size(), 3);
    check("rd_req_a0",   rd_addr_q[0], 8'h20);
    check("rd_req_a1",   rd_addr_q[1], 8'h21);
    check("rd_req_a2",   rd_addr_q[2], 8'h22);
    check("rd_reg_addr", bus.reg_addr, 8'h22);

    // Pointer wrap
    base = wr_addr_q.size();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack); check("wrap_ack_d0", ack, 0);
    send_byte(8'h22, ack); check("wrap_ack_d1", ack, 0);
    i2c_stop(); #Q;
    $display("txn wrap ptr=FF data=11,22 done");
    check("wrap_count",    wr_addr_q.size() - base, 2);
    check("wrap_addr0",    wr_addr_q[base],   8'hFF);
    check("wrap_data0",    wr_data_q[base],   8'h11);
    check("wrap_addr1",    wr_addr_q[base+1], 8'h00);
    check("wrap_data1",    wr_data_q[base+1], 8'h22);
    check("wrap_reg_addr", bus.reg_addr, 8'h01);

    // Abort: STOP after 5 data bits
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h30, ack);
    base = wr_addr_q.size();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    i2c_stop(); #Q;
    $display("txn abort after 5 bits done");
    check("abort_wr_count", wr_addr_q.size() - base, 0);
    check("abort_busy",     bus.busy, 0);
    check("abort_reg_addr", bus.reg_addr, 8'h30);

    // Reset while the target is pulling SDA low in a read address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5 || i == 0);
    sda_m = 1'b1; #Q;
    check("rst_mid_sda_before", bus.sda_o, 0);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    check("rst_mid_sda_o",    bus.sda_o,    1);
    check("rst_mid_reg_addr", bus.reg_addr, 8'h00);
    check("rst_mid_wr_en",    bus.wr_en,    0);
    check("rst_mid_wr_data",  bus.wr_data,  8'h00);
    check("rst_mid_rd_req",   bus.rd_req,   0);
    check("rst_mid_busy",     bus.busy,     0);
    $display("txn reset mid read done");
    scl_m = 1'b1; sda_m = 1'b1;
    #(2*Q);
    rst_n = 1'b1;
    #(4*Q);

    base = wr_addr_q.size();
    i2c_start();
    send_byte(8'hA0, ack); check("post_ack_addr", ack, 0);
    send_byte(8'h05, ack); check("post_ack_ptr",  ack, 0);
    send_byte(8'h77, ack); check("post_ack_d0",   ack, 0);
    i2c_stop(); #Q;
    $display("txn post-reset write ptr=05 data=77 done");
    check("post_wr_count", wr_addr_q.size() - base, 1);
    check("post_wr_addr",  wr_addr_q[base], 8'h05);
    check("post_wr_data",  wr_data_q[base], 8'h77);
    check("post_reg_addr", bus.reg_addr, 8'h06);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
